// File: rtl/mccu_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcode/func
// fields, ALU codes, datapath mux selects and the decoded instruction class.
package mccu_pkg;

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EXE = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_REGA   = 2'b10;
    localparam logic [1:0] PCS_JUMP   = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    typedef enum logic [3:0] {
        C_RALU, C_IALU, C_LOAD, C_STORE, C_BRANCH,
        C_JUMP, C_JR, C_JAL, C_ILLEGAL
    } iclass_e;

    typedef struct packed {
        iclass_e    iclass;
        logic       is_bne;
        logic       shift;
        logic       sext;
        logic [3:0] aluc;
    } dec_t;

endpackage

// File: rtl/mccu_if.sv
// Control-unit <-> datapath bundle: IR fields and flags in, enables and mux selects out.
interface mccu_if #(parameter int ALUC_W = 4);
    logic [5:0]        op;
    logic [5:0]        func;
    logic              z;
    logic              mem_ready;
    logic              wpc;
    logic              wir;
    logic              wmem;
    logic              wreg;
    logic              iord;
    logic              m2reg;
    logic              regrt;
    logic              jal;
    logic              shift;
    logic              sext;
    logic              alusrca;
    logic [1:0]        alusrcb;
    logic [ALUC_W-1:0] aluc;
    logic [1:0]        pcsource;
    logic [2:0]        state;
    logic              illegal;

    modport master (
        input  op, func, z, mem_ready,
        output wpc, wir, wmem, wreg, iord, m2reg, regrt, jal, shift, sext,
               alusrca, alusrcb, aluc, pcsource, state, illegal
    );

    modport slave (
        output op, func, z, mem_ready,
        input  wpc, wir, wmem, wreg, iord, m2reg, regrt, jal, shift, sext,
               alusrca, alusrcb, aluc, pcsource, state, illegal
    );
endinterface

// File: rtl/mccu_decode.sv
// Combinational op/func decode into an instruction class plus the EXE-phase ALU controls.
module mccu_decode
    import mccu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output dec_t       dec
);

    always_comb begin
        dec = '{iclass: C_ILLEGAL, is_bne: 1'b0, shift: 1'b0, sext: 1'b0, aluc: ALUC_ADD};
        case (op)
            OP_R: begin
                case (func)
                    FN_ADD: begin dec.iclass = C_RALU; dec.aluc = ALUC_ADD; end
                    FN_SUB: begin dec.iclass = C_RALU; dec.aluc = ALUC_SUB; end
                    FN_AND: begin dec.iclass = C_RALU; dec.aluc = ALUC_AND; end
                    FN_OR:  begin dec.iclass = C_RALU; dec.aluc = ALUC_OR;  end
                    FN_XOR: begin dec.iclass = C_RALU; dec.aluc = ALUC_XOR; end
                    FN_SLL: begin dec.iclass = C_RALU; dec.aluc = ALUC_SLL; dec.shift = 1'b1; end
                    FN_SRL: begin dec.iclass = C_RALU; dec.aluc = ALUC_SRL; dec.shift = 1'b1; end
                    FN_SRA: begin dec.iclass = C_RALU; dec.aluc = ALUC_SRA; dec.shift = 1'b1; end
                    FN_JR:  dec.iclass = C_JR;
                    default: ;
                endcase
            end
            // logical immediates and lui zero-extend; arithmetic and address forms sign-extend
            OP_ADDI: begin dec.iclass = C_IALU;  dec.aluc = ALUC_ADD; dec.sext = 1'b1; end
            OP_ANDI: begin dec.iclass = C_IALU;  dec.aluc = ALUC_AND; end
            OP_ORI:  begin dec.iclass = C_IALU;  dec.aluc = ALUC_OR;  end
            OP_XORI: begin dec.iclass = C_IALU;  dec.aluc = ALUC_XOR; end
            OP_LUI:  begin dec.iclass = C_IALU;  dec.aluc = ALUC_LUI; end
            OP_LW:   begin dec.iclass = C_LOAD;  dec.aluc = ALUC_ADD; dec.sext = 1'b1; end
            OP_SW:   begin dec.iclass = C_STORE; dec.aluc = ALUC_ADD; dec.sext = 1'b1; end
            OP_BEQ:  begin dec.iclass = C_BRANCH; dec.aluc = ALUC_SUB; end
            OP_BNE:  begin dec.iclass = C_BRANCH; dec.aluc = ALUC_SUB; dec.is_bne = 1'b1; end
            OP_J:    dec.iclass = C_JUMP;
            OP_JAL:  dec.iclass = C_JAL;
            default: ;
        endcase
    end

endmodule

// File: rtl/mccu.sv
// Multi-cycle MIPS-subset control unit: registered phase state, Moore/Mealy
// control outputs derived from the phase, the decoded IR and the memory handshake.
//
//  state | meaning
//  IF    | fetch at PC, PC+4 -> PC and IR load once memory is ready
//  ID    | register read, branch target into ALU-out; jumps finish here
//  EXE   | ALU operation or branch compare/resolve
//  MEM   | data access at ALU-out address, held until memory is ready
//  WB    | register file write (ALU result or load data)
module mccu
    import mccu_pkg::*;
#(
    parameter int ALUC_W   = 4,
    parameter bit WAIT_MEM = 1'b1
) (
    input logic    clk,
    input logic    rst,
    mccu_if.master bus
);

    logic [2:0] state_q, state_d;
    dec_t       dec;
    logic       ready, taken;

    logic       wpc_c, wir_c, wmem_c, wreg_c, iord_c, m2reg_c, regrt_c, jal_c;
    logic       shift_c, sext_c, alusrca_c, illegal_c;
    logic [1:0] alusrcb_c, pcsource_c;
    logic [3:0] aluc_c;

    mccu_decode u_decode (
        .op   (bus.op),
        .func (bus.func),
        .dec  (dec)
    );

    assign ready = bus.mem_ready | ~WAIT_MEM;
    assign taken = dec.is_bne ? ~bus.z : bus.z;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = S_IF;
        wpc_c      = 1'b0;
        wir_c      = 1'b0;
        wmem_c     = 1'b0;
        wreg_c     = 1'b0;
        iord_c     = 1'b0;
        m2reg_c    = 1'b0;
        regrt_c    = 1'b0;
        jal_c      = 1'b0;
        shift_c    = 1'b0;
        sext_c     = 1'b0;
        alusrca_c  = 1'b0;
        illegal_c  = 1'b0;
        alusrcb_c  = SRCB_REG;
        pcsource_c = PCS_ALU;
        aluc_c     = ALUC_ADD;
        case (state_q)
            S_IF: begin
                alusrcb_c = SRCB_FOUR;
                wir_c     = ready;
                wpc_c     = ready;
                state_d   = ready ? S_ID : S_IF;
            end
            S_ID: begin
                alusrcb_c = SRCB_BR;
                case (dec.iclass)
                    C_JUMP:    begin wpc_c = 1'b1; pcsource_c = PCS_JUMP; end
                    C_JR:      begin wpc_c = 1'b1; pcsource_c = PCS_REGA; end
                    C_JAL: begin
                        wpc_c      = 1'b1;
                        pcsource_c = PCS_JUMP;
                        wreg_c     = 1'b1;
                        jal_c      = 1'b1;
                    end
                    C_ILLEGAL: illegal_c = 1'b1;
                    default:   state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                alusrca_c = 1'b1;
                aluc_c    = dec.aluc;
                shift_c   = dec.shift;
                sext_c    = dec.sext;
                case (dec.iclass)
                    C_RALU:  begin alusrcb_c = SRCB_REG; state_d = S_WB;  end
                    C_IALU:  begin alusrcb_c = SRCB_IMM; state_d = S_WB;  end
                    C_LOAD,
                    C_STORE: begin alusrcb_c = SRCB_IMM; state_d = S_MEM; end
                    C_BRANCH: begin
                        alusrcb_c  = SRCB_REG;
                        wpc_c      = taken;
                        pcsource_c = PCS_ALUOUT;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                iord_c = 1'b1;
                if (dec.iclass == C_STORE) begin
                    wmem_c  = ready;
                    state_d = ready ? S_IF : S_MEM;
                end else if (dec.iclass == C_LOAD) begin
                    state_d = ready ? S_WB : S_MEM;
                end
            end
            S_WB: begin
                wreg_c  = 1'b1;
                regrt_c = (dec.iclass == C_IALU) || (dec.iclass == C_LOAD);
                m2reg_c = (dec.iclass == C_LOAD);
            end
            default: ;
        endcase
    end

    // Outputs are forced quiet while rst is high so an access in flight cannot write.
    assign bus.wpc      = wpc_c & ~rst;
    assign bus.wir      = wir_c & ~rst;
    assign bus.wmem     = wmem_c & ~rst;
    assign bus.wreg     = wreg_c & ~rst;
    assign bus.iord     = iord_c & ~rst;
    assign bus.m2reg    = m2reg_c & ~rst;
    assign bus.regrt    = regrt_c & ~rst;
    assign bus.jal      = jal_c & ~rst;
    assign bus.shift    = shift_c & ~rst;
    assign bus.sext     = sext_c & ~rst;
    assign bus.alusrca  = alusrca_c & ~rst;
    assign bus.illegal  = illegal_c & ~rst;
    assign bus.alusrcb  = rst ? 2'b00 : alusrcb_c;
    assign bus.pcsource = rst ? 2'b00 : pcsource_c;
    assign bus.aluc     = rst ? '0 : ALUC_W'(aluc_c);
    assign bus.state    = rst ? S_IF : state_q;

endmodule

// File: tb/tb_mccu.sv
// Scoreboarded bench for mccu: an instruction-level model lists the expected
// control vector for every cycle of each instruction; a monitor compares at negedge.
module tb_mccu;

    logic clk = 1'b0;
    logic rst;

    mccu_if #(.ALUC_W(4)) bus ();

    mccu #(.ALUC_W(4), .WAIT_MEM(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] state;
        logic wpc, wir, wmem, wreg, iord, m2reg, regrt, jal, illegal, shift, sext, alusrca;
        logic [1:0] pcsource;
        logic [1:0] alusrcb;
        logic [3:0] aluc;
    } ov_t;

    typedef struct packed {
        ov_t         v;
        ov_t         m;
        logic [47:0] tag;
    } exp_t;

    typedef enum int { K_RALU, K_IALU, K_LW, K_SW, K_BR, K_J, K_JR, K_JAL, K_ILL } kind_e;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: begin
                if (fn == 6'b001000) return K_JR;
                if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                               6'b000000, 6'b000010, 6'b000011}) return K_RALU;
                return K_ILL;
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111: return K_IALU;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100, 6'b000101: return K_BR;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) begin
            case (fn)
                6'b100010: return 4'b0100;
                6'b100100: return 4'b0001;
                6'b100101: return 4'b0101;
                6'b100110: return 4'b0010;
                6'b000000: return 4'b0011;
                6'b000010: return 4'b0111;
                6'b000011: return 4'b1111;
                default:   return 4'b0000;
            endcase
        end
        case (op)
            6'b001100: return 4'b0001;
            6'b001101: return 4'b0101;
            6'b001110: return 4'b0010;
            6'b001111: return 4'b0110;
            6'b000100, 6'b000101: return 4'b0100;
            default:   return 4'b0000;
        endcase
    endfunction

    // Which fields the model pins down in each phase; the rest are don't-care.
    function automatic ov_t mask_of(input logic [2:0] st);
        ov_t m;
        m = '0;
        m.state = '1; m.wpc = 1'b1; m.wir = 1'b1; m.wmem = 1'b1; m.wreg = 1'b1;
        m.illegal = 1'b1; m.jal = 1'b1;
        case (st)
            3'd0: begin m.iord = 1'b1; m.alusrca = 1'b1; m.alusrcb = '1; m.aluc = '1; m.pcsource = '1; end
            3'd1: begin m.alusrca = 1'b1; m.alusrcb = '1; m.aluc = '1; end
            3'd2: begin m.alusrca = 1'b1; m.alusrcb = '1; m.aluc = '1; m.shift = 1'b1; m.sext = 1'b1; end
            3'd3: m.iord = 1'b1;
            default: begin m.m2reg = 1'b1; m.regrt = 1'b1; end
        endcase
        return m;
    endfunction

    task automatic cyc(input ov_t v, input ov_t m, input logic [47:0] tag, input logic mr);
        exp_t e;
        bus.mem_ready = mr;
        if (v.wpc) m.pcsource = '1;
        e.v = v; e.m = m; e.tag = tag;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) cyc('0, '1, "rst", 1'b1);
        rst = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zf,
                             input int wif, input int wmm, input bit abort_mem);
        kind_e k;
        ov_t   v, m;
        k = classify(op, fn);
        bus.op = op; bus.func = fn; bus.z = zf;

        for (int i = 0; i <= wif; i++) begin
            v = '0; v.alusrcb = 2'b01;
            v.wir = (i == wif); v.wpc = (i == wif);
            cyc(v, mask_of(3'd0), "if", (i == wif));
        end

        v = '0; v.state = 3'd1; v.alusrcb = 2'b11;
        case (k)
            K_J:   begin v.wpc = 1'b1; v.pcsource = 2'b11; end
            K_JR:  begin v.wpc = 1'b1; v.pcsource = 2'b10; end
            K_JAL: begin v.wpc = 1'b1; v.pcsource = 2'b11; v.wreg = 1'b1; v.jal = 1'b1; end
            K_ILL: v.illegal = 1'b1;
            default: ;
        endcase
        cyc(v, mask_of(3'd1), "id", 1'($urandom));
        if (k inside {K_J, K_JR, K_JAL, K_ILL}) return;

        v = '0; m = mask_of(3'd2); v.state = 3'd2; v.alusrca = 1'b1;
        v.aluc = alu_of(op, fn);
        case (k)
            K_RALU: v.shift = (fn inside {6'b000000, 6'b000010, 6'b000011});
            K_BR: begin
                m.sext = 1'b0;
                v.wpc = (op == 6'b000100) ? zf : ~zf;
                v.pcsource = 2'b01;
            end
            default: begin v.alusrcb = 2'b10; v.sext = (op inside {6'b001000, 6'b100011, 6'b101011}); end
        endcase
        cyc(v, m, "exe", 1'($urandom));
        if (k == K_BR) return;

        if (k inside {K_LW, K_SW}) begin
            for (int i = 0; i <= wmm; i++) begin
                if (abort_mem && i == 1) begin
                    do_reset(2);
                    return;
                end
                v = '0; v.state = 3'd3; v.iord = 1'b1;
                v.wmem = (k == K_SW) && (i == wmm);
                cyc(v, mask_of(3'd3), "mem", (i == wmm));
            end
            if (k == K_SW) return;
        end

        v = '0; v.state = 3'd4; v.wreg = 1'b1;
        v.regrt = (k != K_RALU); v.m2reg = (k == K_LW);
        cyc(v, mask_of(3'd4), "wb", 1'($urandom));
    endtask

    always @(negedge clk) begin
        exp_t e;
        ov_t  a;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            a.state = bus.state; a.wpc = bus.wpc; a.wir = bus.wir; a.wmem = bus.wmem;
            a.wreg = bus.wreg; a.iord = bus.iord; a.m2reg = bus.m2reg; a.regrt = bus.regrt;
            a.jal = bus.jal; a.illegal = bus.illegal; a.shift = bus.shift; a.sext = bus.sext;
            a.alusrca = bus.alusrca; a.pcsource = bus.pcsource; a.alusrcb = bus.alusrcb;
            a.aluc = bus.aluc;
            checks++;
            if ((a & e.m) != (e.v & e.m)) begin
                errors++;
                $display("FAIL %0s t=%0t actual=%06h required=%06h care=%06h",
                         e.tag, $time, a, e.v, e.m);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    logic [11:0] legal_tab [20];

    initial begin
        logic [11:0] pick;
        int          r;
        legal_tab = '{
            {6'b000000, 6'b100000}, {6'b000000, 6'b100010}, {6'b000000, 6'b100100},
            {6'b000000, 6'b100101}, {6'b000000, 6'b100110}, {6'b000000, 6'b000000},
            {6'b000000, 6'b000010}, {6'b000000, 6'b000011}, {6'b000000, 6'b001000},
            {6'b001000, 6'b000000}, {6'b001100, 6'b000000}, {6'b001101, 6'b000000},
            {6'b001110, 6'b000000}, {6'b001111, 6'b000000}, {6'b100011, 6'b000000},
            {6'b101011, 6'b000000}, {6'b000100, 6'b000000}, {6'b000101, 6'b000000},
            {6'b000010, 6'b000000}, {6'b000011, 6'b000000}
        };
        rst = 1'b1;
        bus.op = 6'b100011; bus.func = 6'b000000; bus.z = 1'b0; bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;

        do_reset(2);
        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0);
        run_instr(6'b100011, 6'b000000, 1'b0, 3, 3, 1'b0);
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, 1'b0);
        run_instr(6'b000101, 6'b000000, 1'b1, 0, 0, 1'b0);
        run_instr(6'b000011, 6'b000000, 1'b0, 1, 0, 1'b0);
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0);
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 2, 1'b1);
        run_instr(6'b101011, 6'b000000, 1'b0, 1, 2, 1'b0);
        run_instr(6'b000000, 6'b000011, 1'b0, 0, 0, 1'b0);
        run_instr(6'b001111, 6'b000000, 1'b0, 0, 0, 1'b0);
        run_instr(6'b000000, 6'b111111, 1'b0, 0, 0, 1'b0);

        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 23);
            if (r < 20) pick = legal_tab[r];
            else        pick = 12'($urandom);
            run_instr(pick[11:6], pick[5:0], 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending entries", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
